// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I-cache/D-cache memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache, D-cache) arbiter in front of a single-outstanding memory port,
// with fair tie-breaking and per-port completed-transfer statistics.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic              mem_valid,
  output logic [15:0]       ic_xfer_cnt,
  output logic [15:0]       dc_xfer_cnt
);

  arbState_e         state;
  logic              owner;
  logic              lastGrant;
  logic              wrQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              anyReq;
  logic              grantOwner;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    anyReq = ic_req | dc_req;
    if (ic_req && dc_req) begin
      grantOwner = ~lastGrant;
    end else begin
      grantOwner = dc_req ? OWN_DC : OWN_IC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IC;
      lastGrant <= OWN_IC;
      wrQ       <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner     <= grantOwner;
            lastGrant <= grantOwner;
            if (grantOwner == OWN_DC) begin
              addrQ  <= dc_addr;
              wrQ    <= dc_wr;
              wdataQ <= dc_wdata;
            end else begin
              addrQ  <= ic_addr;
              wrQ    <= 1'b0;
              wdataQ <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_stall) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            if (!wrQ) begin
              if (owner == OWN_IC) begin
                ic_rdata <= mem_rdata;
              end else begin
                dc_rdata <= mem_rdata;
              end
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_wr    = (state == ISSUE) && wrQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign ic_done   = (state == DONE) && (owner == OWN_IC);
  assign dc_done   = (state == DONE) && (owner == OWN_DC);

  sat_counter16 uIcCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ic_done),
    .count (ic_xfer_cnt)
  );

  sat_counter16 uDcCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dc_done),
    .count (dc_xfer_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: arbitration, latency, stall, reset and saturation.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [15:0] ic_addr;
  logic [15:0] ic_rdata;
  logic        ic_done;
  logic        dc_req;
  logic        dc_wr;
  logic [15:0] dc_addr;
  logic [15:0] dc_wdata;
  logic [15:0] dc_rdata;
  logic        dc_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_stall;
  logic        mem_valid;
  logic [15:0] ic_xfer_cnt;
  logic [15:0] dc_xfer_cnt;

  int nTests = 0;
  int nFail  = 0;

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ic_req      (ic_req),
    .ic_addr     (ic_addr),
    .ic_rdata    (ic_rdata),
    .ic_done     (ic_done),
    .dc_req      (dc_req),
    .dc_wr       (dc_wr),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_rdata    (dc_rdata),
    .dc_done     (dc_done),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_stall   (mem_stall),
    .mem_valid   (mem_valid),
    .ic_xfer_cnt (ic_xfer_cnt),
    .dc_xfer_cnt (dc_xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    ic_req    = 1'b0;
    ic_addr   = 16'h0000;
    dc_req    = 1'b0;
    dc_wr     = 1'b0;
    dc_addr   = 16'h0000;
    dc_wdata  = 16'h0000;
    mem_rdata = 16'h0000;
    mem_stall = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitMemEn(output int cyc);
    cyc = 0;
    while (mem_en !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nTests++;
    if (mem_en !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      nFail++;
      $display("FAIL reset_mem: en=%b wr=%b addr=%h wdata=%h want all 0", mem_en, mem_wr, mem_addr, mem_wdata);
    end
    nTests++;
    if (ic_done !== 1'b0 || dc_done !== 1'b0 || ic_rdata !== 16'h0 || dc_rdata !== 16'h0) begin
      nFail++;
      $display("FAIL reset_ports: icd=%b dcd=%b icr=%h dcr=%h want all 0", ic_done, dc_done, ic_rdata, dc_rdata);
    end
    nTests++;
    if (ic_xfer_cnt !== 16'h0 || dc_xfer_cnt !== 16'h0) begin
      nFail++;
      $display("FAIL reset_cnt: ic=%h dc=%h want 0", ic_xfer_cnt, dc_xfer_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ic_read();
    ic_req  = 1'b1;
    ic_addr = 16'h0040;
    tick();
    nTests++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0040 || mem_wr !== 1'b0) begin
      nFail++;
      $display("FAIL icrd_c1_issue: en=%b addr=%h wr=%b want 1/0040/0", mem_en, mem_addr, mem_wr);
    end
    tick();
    nTests++;
    if (mem_en !== 1'b0) begin
      nFail++;
      $display("FAIL icrd_c2_wait: mem_en=%b want 0", mem_en);
    end
    mem_valid = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    nTests++;
    if (ic_done !== 1'b1 || dc_done !== 1'b0 || ic_rdata !== 16'hBEEF) begin
      nFail++;
      $display("FAIL icrd_c3_done: icd=%b dcd=%b icr=%h want 1/0/beef", ic_done, dc_done, ic_rdata);
    end
    mem_valid = 1'b0;
    ic_req    = 1'b0;
    tick();
    nTests++;
    if (ic_done !== 1'b0 || ic_xfer_cnt !== 16'd1 || dc_xfer_cnt !== 16'd0 || ic_rdata !== 16'hBEEF) begin
      nFail++;
      $display("FAIL icrd_c4_after: icd=%b iccnt=%0d dccnt=%0d icr=%h want 0/1/0/beef",
               ic_done, ic_xfer_cnt, dc_xfer_cnt, ic_rdata);
    end
  endtask

  task automatic test_tie();
    doReset();
    ic_req  = 1'b1;
    ic_addr = 16'h0100;
    dc_req  = 1'b1;
    dc_wr   = 1'b0;
    dc_addr = 16'h0200;
    tick();
    nTests++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0200) begin
      nFail++;
      $display("FAIL tie_first_dc: en=%b addr=%h want 1/0200", mem_en, mem_addr);
    end
    tick();
    mem_valid = 1'b1;
    mem_rdata = 16'hD00D;
    tick();
    nTests++;
    if (dc_done !== 1'b1 || ic_done !== 1'b0 || dc_rdata !== 16'hD00D) begin
      nFail++;
      $display("FAIL tie_dc_done: dcd=%b icd=%b dcr=%h want 1/0/d00d", dc_done, ic_done, dc_rdata);
    end
    mem_valid = 1'b0;
    dc_req    = 1'b0;
    tick();
    nTests++;
    if (mem_en !== 1'b0) begin
      nFail++;
      $display("FAIL tie_gap: mem_en=%b want 0 in cycle after dc_done", mem_en);
    end
    tick();
    nTests++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0100) begin
      nFail++;
      $display("FAIL tie_second_ic: en=%b addr=%h want 1/0100", mem_en, mem_addr);
    end
    tick();
    mem_valid = 1'b1;
    mem_rdata = 16'h1C1C;
    tick();
    nTests++;
    if (ic_done !== 1'b1 || ic_rdata !== 16'h1C1C || dc_rdata !== 16'hD00D) begin
      nFail++;
      $display("FAIL tie_ic_done: icd=%b icr=%h dcr=%h want 1/1c1c/d00d", ic_done, ic_rdata, dc_rdata);
    end
    mem_valid = 1'b0;
    ic_req    = 1'b0;
    tick();
    nTests++;
    if (ic_xfer_cnt !== 16'd1 || dc_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("FAIL tie_cnt: ic=%0d dc=%0d want 1/1", ic_xfer_cnt, dc_xfer_cnt);
    end
  endtask

  task automatic test_dc_write_stall();
    int enCycles;
    int doneCount;
    dc_req    = 1'b1;
    dc_wr     = 1'b1;
    dc_addr   = 16'h1000;
    dc_wdata  = 16'h1234;
    mem_stall = 1'b1;
    enCycles  = 0;
    doneCount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTests++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h1000 || mem_wdata !== 16'h1234) begin
        nFail++;
        $display("FAIL wrst_issue%0d: en=%b wr=%b addr=%h wdata=%h want 1/1/1000/1234",
                 i, mem_en, mem_wr, mem_addr, mem_wdata);
      end
      if (mem_en === 1'b1) enCycles++;
      mem_stall = (i < 2);
      // mem_valid during ISSUE must not advance or complete the access
      mem_valid = (i < 2);
      mem_rdata = 16'hFFFF;
    end
    tick();
    nTests++;
    if (mem_en !== 1'b0 || dc_done !== 1'b0) begin
      nFail++;
      $display("FAIL wrst_wait: en=%b dcd=%b want 0/0", mem_en, dc_done);
    end
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    dc_req    = 1'b0;
    dc_wr     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dc_done === 1'b1) doneCount++;
      if (mem_en === 1'b1) enCycles++;
      tick();
    end
    nTests++;
    if (enCycles != 3 || doneCount != 1) begin
      nFail++;
      $display("FAIL wrst_counts: en_cycles=%0d done_pulses=%0d want 3/1", enCycles, doneCount);
    end
    nTests++;
    if (dc_rdata !== 16'hD00D || dc_xfer_cnt !== 16'd2) begin
      nFail++;
      $display("FAIL wrst_rdata: dcr=%h dccnt=%0d want d00d/2", dc_rdata, dc_xfer_cnt);
    end
  endtask

  task automatic test_reset_wait();
    int doneSeen;
    dc_req  = 1'b1;
    dc_wr   = 1'b0;
    dc_addr = 16'h2222;
    tick();
    tick();
    nTests++;
    if (dut.state !== WAIT) begin
      nFail++;
      $display("FAIL rstw_in_wait: state=%0d want %0d", dut.state, WAIT);
    end
    #2;
    rst_n  = 1'b0;
    dc_req = 1'b0;
    #1;
    nTests++;
    if (dut.state !== IDLE || ic_xfer_cnt !== 16'd0 || dc_xfer_cnt !== 16'd0) begin
      nFail++;
      $display("FAIL rstw_async: state=%0d ic=%0d dc=%0d want IDLE/0/0", dut.state, ic_xfer_cnt, dc_xfer_cnt);
    end
    #1;
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 16'h5A5A;
    doneSeen  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dc_done !== 1'b0 || ic_done !== 1'b0 || mem_en !== 1'b0) doneSeen++;
    end
    mem_valid = 1'b0;
    nTests++;
    if (doneSeen != 0 || dut.state !== IDLE || dc_rdata !== 16'h0000 || dc_xfer_cnt !== 16'd0) begin
      nFail++;
      $display("FAIL rstw_late_valid: activity=%0d state=%0d dcr=%h dccnt=%0d want 0/IDLE/0000/0",
               doneSeen, dut.state, dc_rdata, dc_xfer_cnt);
    end
  endtask

  task automatic test_alternation();
    int cyc;
    logic expDc;
    logic [15:0] expAddr;
    doReset();
    ic_req  = 1'b1;
    ic_addr = 16'hA000;
    dc_req  = 1'b1;
    dc_wr   = 1'b0;
    dc_addr = 16'hB000;
    for (int t = 0; t < 6; t++) begin
      expDc   = (t % 2 == 0);
      expAddr = expDc ? 16'hB000 : 16'hA000;
      waitMemEn(cyc);
      nTests++;
      if (mem_en !== 1'b1 || mem_addr !== expAddr) begin
        nFail++;
        $display("FAIL alt_grant%0d: en=%b addr=%h want 1/%h", t, mem_en, mem_addr, expAddr);
      end
      tick();
      mem_valid = 1'b1;
      mem_rdata = 16'h0100 + 16'(t);
      tick();
      mem_valid = 1'b0;
      nTests++;
      if (dc_done !== expDc || ic_done !== !expDc) begin
        nFail++;
        $display("FAIL alt_done%0d: dcd=%b icd=%b want %b/%b", t, dc_done, ic_done, expDc, !expDc);
      end
      if (expDc) dc_req = 1'b0;
      else ic_req = 1'b0;
      tick();
      ic_req = 1'b1;
      dc_req = 1'b1;
    end
    // Let the arbiter finish anything it may have granted in the final IDLE cycle.
    ic_req = 1'b0;
    dc_req = 1'b0;
    waitMemEn(cyc);
    if (mem_en === 1'b1) begin
      tick();
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
      tick();
    end
    nTests++;
    if (ic_xfer_cnt !== 16'd3 || dc_xfer_cnt !== 16'd3 || ic_rdata !== 16'h0105 || dc_rdata !== 16'h0104) begin
      nFail++;
      $display("FAIL alt_cnt: ic=%0d dc=%0d icr=%h dcr=%h want 3/3/0105/0104",
               ic_xfer_cnt, dc_xfer_cnt, ic_rdata, dc_rdata);
    end
  endtask

  task automatic test_saturation();
    force dut.uDcCnt.count = 16'hFFFE;
    tick();
    release dut.uDcCnt.count;
    tick();
    nTests++;
    if (dc_xfer_cnt !== 16'hFFFE) begin
      nFail++;
      $display("FAIL sat_preload: dc_cnt=%h want fffe", dc_xfer_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      dc_req   = 1'b1;
      dc_wr    = 1'b1;
      dc_addr  = 16'h3000;
      dc_wdata = 16'h0F0F;
      tick();
      tick();
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
      dc_req    = 1'b0;
      dc_wr     = 1'b0;
      tick();
      nTests++;
      if (dc_xfer_cnt !== 16'hFFFF || ic_xfer_cnt !== 16'd3) begin
        nFail++;
        $display("FAIL sat_xfer%0d: dc_cnt=%h ic_cnt=%0d want ffff/3", k, dc_xfer_cnt, ic_xfer_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_tie();
    test_dc_write_stall();
    test_reset_wait();
    test_alternation();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-002 The block SHALL have these I-cache port signals:
- ic_req  input  1  fill request, held until ic_done
- ic_addr  input  16  read address, stable while ic_req
- ic_rdata  output  16  read data, valid with ic_done
- ic_done  output  1  one-cycle completion pulse
REQ-003 The block SHALL have these D-cache port signals:
- dc_req  input  1  request, held until dc_done
- dc_wr  input  1  1=write, 0=read
- dc_addr  input  16  address
- dc_wdata  input  16  write data
- dc_rdata  output  16  read data, valid with dc_done
- dc_done  output  1  one-cycle completion pulse
REQ-004 The block SHALL have these memory port signals:
- mem_en  output  1  issue strobe
- mem_wr  output  1  write qualifier
- mem_addr  output  16  address
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data
- mem_stall  input  1  memory cannot accept the issue this cycle
- mem_valid  input  1  access complete, mem_rdata valid
REQ-005 The block SHALL have two statistics outputs: ic_xfer_cnt (output, 16, completed I-cache transfers) and dc_xfer_cnt (output, 16, completed D-cache transfers).

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-007 IDLE SHALL grant a requester when at least one of ic_req or dc_req is high, latch the owner, address, write flag and write data into registers, and go to ISSUE.
REQ-008 When both requests are high in IDLE, the grant SHALL go to the requester not granted last; last_grant SHALL reset to I-cache, so D-cache wins the first tie.
REQ-009 ISSUE SHALL drive mem_en=1 with the latched mem_wr, mem_addr and mem_wdata; if mem_stall=1 it SHALL stay in ISSUE with outputs unchanged, otherwise it SHALL go to WAIT.
REQ-010 WAIT SHALL hold mem_en=0 and go to DONE on the first cycle mem_valid=1, registering mem_rdata for a read.
REQ-011 DONE SHALL pulse the owner's done for exactly one cycle, present the owner's rdata (registered), increment the owner's counter, and return to IDLE.
REQ-012 Minimum latency SHALL be: req sampled in IDLE at cycle 0, mem_en at cycle 1, done at cycle 3 when mem_valid arrives at cycle 2; each mem_stall cycle and each extra WAIT cycle adds one cycle.
REQ-013 In IDLE, a requester whose done is asserted in that same cycle SHALL NOT be granted; requesters deassert req during done.
REQ-014 mem_valid SHALL be ignored outside WAIT.
REQ-015 ic_rdata and dc_rdata SHALL hold their values until the next read completion for that port; a D-cache write SHALL leave dc_rdata unchanged.
REQ-016 ic_xfer_cnt and dc_xfer_cnt SHALL saturate at 0xFFFF.
REQ-017 mem_en SHALL be high only in ISSUE, and at most one transaction SHALL be outstanding at any time.

Reset
REQ-018 Asserting rst_n=0 SHALL asynchronously force state IDLE, last_grant I-cache, and all outputs and counters 0.
REQ-019 A reset during ISSUE or WAIT SHALL abandon the transaction, and no done SHALL be generated for it.
REQ-020 The first grant after rst_n rises SHALL be no earlier than the first rising clk edge with rst_n=1.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the state enum, the ADDR_W=16 and DATA_W=16 constants, and the owner encoding (OWN_IC=0, OWN_DC=1).
REQ-022 The block SHALL contain one sub-module, sat_counter16 (enable, saturating, async reset), instantiated twice.

Verification
REQ-023 Single I-cache read: ic_req with ic_addr=0x0040, mem_valid one cycle after mem_en, mem_rdata=0xBEEF -> ic_done at cycle 3, ic_rdata=0xBEEF, ic_xfer_cnt=1.
REQ-024 Tie after reset: ic_req and dc_req both high -> D-cache served first, then I-cache; mem_en for the second transaction no earlier than 1 cycle after dc_done.
REQ-025 D-cache write under stall: dc_wr=1, dc_addr=0x1000, dc_wdata=0x1234, mem_stall held 2 cycles -> mem_en high for 3 cycles with fixed address/data, dc_done once, dc_rdata unchanged.
REQ-026 Reset in WAIT: rst_n pulsed low mid-access, then a late mem_valid -> no done, counters 0, state IDLE.
REQ-027 Alternation: both requesters continuously re-requesting for 6 transactions -> grants strictly alternate DC, IC, DC, IC, DC, IC.
REQ-028 Saturation: counter preloaded to 0xFFFE via force, two D-cache completions -> dc_xfer_cnt=0xFFFF and stays there.
